mem_responder: RTL

Unified instruction/data memory that sits on the far side of the multicycle core's memory port and answers the requests the control FSM issues in FETCH, MEMREAD and MEMWRITE. It accepts one request at a time over a valid/ready handshake and models a fixed access latency with a countdown. It performs RV64 byte/half/word/double stores with byte-lane merging, and loads with sign/zero extension selected by funct3. Misaligned or illegal-size accesses are flagged instead of executed.

---
 rtl/mem_responder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: unified instruction/data memory behind the core's memory port.
// Accepts one request at a time, waits a fixed number of cycles, then performs
// an RV64 load (with sign/zero extension) or a byte-lane-merged store and
// returns a one-cycle response. Misaligned or illegal-size accesses are
// reported through o_misaligned and leave the array untouched.
module mem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        arstn,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [63:0] i_addr,
   input  logic        i_write_en,
   input  logic [2:0]  i_func_3,
   input  logic [63:0] i_wdata,
   output logic        o_rsp_valid,
   output logic [63:0] o_rdata,
   output logic        o_misaligned
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W+2:0]   addr_q;
   logic               wr_q;
   logic [2:0]         func_q;
   logic [63:0]        wdata_q;

   logic [63:0]        mem [DEPTH];

   logic [IDX_W-1:0]   idx;
   logic [2:0]         off;
   logic [5:0]         shift;
   logic [1:0]         size;
   logic               err;
   logic [7:0]         lane_mask;
   logic [63:0]        bit_mask;
   logic [63:0]        cur_word;
   logic [63:0]        raw;
   logic [63:0]        merged;
   logic [63:0]        load_val;
   logic               last_wait;
   logic               commit;

   // Upper address bits alias onto the array and are deliberately dropped.
   wire unused_addr = ^i_addr[63:IDX_W+3];

   assign idx       = addr_q[3 +: IDX_W];
   assign off       = addr_q[2:0];
   assign shift     = {off, 3'b000};
   assign size      = func_q[1:0];
   assign cur_word  = mem[idx];
   assign last_wait = (state == WAIT) && (cnt == '0);
   assign commit    = last_wait && wr_q && !err;

   // Decode the captured request: legality, affected byte lanes, merged store
   // word and the extended load value.
   always_comb begin
      err       = 1'b0;
      lane_mask = 8'h00;
      bit_mask  = '0;
      raw       = cur_word >> shift;
      load_val  = '0;
      case (size)
         2'd0: begin
            lane_mask = 8'h01;
            load_val  = func_q[2] ? {56'd0, raw[7:0]} : {{56{raw[7]}}, raw[7:0]};
         end
         2'd1: begin
            lane_mask = 8'h03;
            err       = off[0];
            load_val  = func_q[2] ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
         end
         2'd2: begin
            lane_mask = 8'h0F;
            err       = (off[1:0] != 2'd0);
            load_val  = func_q[2] ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
         end
         default: begin
            lane_mask = 8'hFF;
            err       = (off != 3'd0);
            load_val  = raw;
         end
      endcase
      if (wr_q ? func_q[2] : (func_q == 3'b111)) begin
         err = 1'b1;
      end
      lane_mask = lane_mask << off;
      for (int i = 0; i < 8; i++) begin
         bit_mask[8*i +: 8] = {8{lane_mask[i]}};
      end
      merged = (cur_word & ~bit_mask) | ((wdata_q << shift) & bit_mask);
   end

   // Array write port; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (commit) begin
         mem[idx] <= merged;
      end
   end

   // Request/response FSM with all handshake outputs registered.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state        <= IDLE;
         cnt          <= '0;
         addr_q       <= '0;
         wr_q         <= 1'b0;
         func_q       <= 3'd0;
         wdata_q      <= '0;
         o_req_ready  <= 1'b1;
         o_rsp_valid  <= 1'b0;
         o_rdata      <= '0;
         o_misaligned <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               o_rsp_valid <= 1'b0;
               if (i_req_valid) begin
                  addr_q      <= i_addr[IDX_W+2:0];
                  wr_q        <= i_write_en;
                  func_q      <= i_func_3;
                  wdata_q     <= i_wdata;
                  cnt         <= CNT_W'(LATENCY);
                  o_req_ready <= 1'b0;
                  state       <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state        <= RESP;
                  o_rsp_valid  <= 1'b1;
                  o_misaligned <= err;
                  o_rdata      <= (err || wr_q) ? 64'd0 : load_val;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               o_rsp_valid <= 1'b0;
               o_req_ready <= 1'b1;
               state       <= IDLE;
            end
            default: begin
               o_rsp_valid <= 1'b0;
               o_req_ready <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule
